inst_loader: RTL

Serial program loader that drives the instruction memory's write port (write_en / write_addr / write_data). It accepts a byte stream from a UART receiver with a valid/ready handshake, frames it as length + words + checksum, and writes each assembled 32-bit word to consecutive instruction addresses. While loading it holds the core in reset, and it reports completion or error to top level.

---
 rtl/inst_loader_pkg.sv | 17 +
 rtl/inst_loader_byte_packer.sv | 35 +++
 rtl/inst_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the serial instruction loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } ld_state_e;

  localparam int unsigned FieldBytes = 4;
  localparam logic [31:0] WordStride = 32'd4;
  localparam logic [1:0]  LastLane   = 2'(FieldBytes - 1);

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Assembles consecutive bytes into little-endian 32-bit words.
module inst_loader_byte_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_q;
  logic [31:0] shreg_q;

  // Merge the incoming byte so the completed word is available on its final byte.
  always_comb begin
    word = shreg_q;
    word[idx_q*8 +: 8] = byte_in;
  end

  assign word_valid = byte_en && (idx_q == LastLane);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx_q   <= 2'd0;
      shreg_q <= 32'd0;
    end else if (byte_en) begin
      shreg_q <= word;
      idx_q   <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Serial loader: frames LEN + words + CSUM from a byte stream and writes instruction memory.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        write_en,
  output logic [31:0] write_addr,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] words_loaded
);

  localparam logic [31:0] MemWordsW = 32'(MEM_WORDS);

  ld_state_e   state_q;
  logic        busy_q, done_q, error_q, write_en_q;
  logic [31:0] write_addr_q, next_addr_q, write_data_q;
  logic [31:0] words_loaded_q, len_q, sum_q;

  logic        consume, start_ok, word_valid;
  logic [31:0] word;

  assign consume  = rx_valid && busy_q;
  assign start_ok = start && (state_q == StIdle || state_q == StDone || state_q == StErr);

  inst_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_en    (consume),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      write_en_q     <= 1'b0;
      write_addr_q   <= BASE_ADDR;
      next_addr_q    <= BASE_ADDR;
      write_data_q   <= 32'd0;
      words_loaded_q <= 32'd0;
      len_q          <= 32'd0;
      sum_q          <= 32'd0;
    end else begin
      write_en_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start_ok) begin
            state_q        <= StLen;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            sum_q          <= 32'd0;
            words_loaded_q <= 32'd0;
            next_addr_q    <= BASE_ADDR;
          end
        end
        StLen: begin
          if (word_valid) begin
            len_q <= word;
            if (word == 32'd0) begin
              state_q <= StCsum;
            end else if (word > MemWordsW) begin
              state_q <= StErr;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (word_valid) begin
            write_en_q     <= 1'b1;
            write_data_q   <= word;
            write_addr_q   <= next_addr_q;
            next_addr_q    <= next_addr_q + WordStride;
            sum_q          <= sum_q + word;
            words_loaded_q <= words_loaded_q + 32'd1;
            if (words_loaded_q + 32'd1 == len_q) begin
              state_q <= StCsum;
            end
          end
        end
        StCsum: begin
          if (word_valid) begin
            busy_q <= 1'b0;
            if (word == sum_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StErr;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready     = busy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign write_en     = write_en_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign words_loaded = words_loaded_q;

endmodule
